// File: rtl/mem_stage_pipe_pkg.sv
// Shared encodings and byte-lane helpers for the MEM stage.
// Access-size codes, FSM state type, lane enables, load extension and address alignment.
package mem_stage_pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Size code 2'b11 is treated as a word everywhere.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {a, 3'b000});
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_bytelane_ram.sv
// Data RAM: DEPTH_WORDS x 32 with four byte-write enables.
// Synchronous write, combinational read; contents are never reset.
module mem_bytelane_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// MIPS MEM stage with byte-lane data RAM, wait-state FSM and MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: suppress misaligned half/word accesses and flag them.
//
// state | meaning
// IDLE  | accepting; zero-wait and non-memory ops complete here
// WAIT  | memory access in flight, cnt_q counts down to the commit cycle
module mem_stage_pipe
  import mem_stage_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [REG_AW-1:0] write_reg,
  output logic              stall_out,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_result,
  output logic              misalign
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_op, mis, stall, commit_mem;
  logic [1:0]         a_lo;
  logic [3:0]         ram_we;
  logic [31:0]        ram_wdata, ram_rdata, ld_data;

  logic               wb_valid_q, wb_valid_d;
  logic               wb_reg_write_q, wb_reg_write_d;
  logic               wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [REG_AW-1:0]  wb_write_reg_q, wb_write_reg_d;
  logic [DATA_W-1:0]  wb_read_data_q, wb_read_data_d;
  logic [DATA_W-1:0]  wb_result_q, wb_result_d;
  logic               misalign_q, misalign_d;

  assign mem_op = in_valid & (mem_read | mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = mem_op & (((mem_size == SZ_HALF) & alu_result[0]) |
                         (mem_size[1] & (|alu_result[1:0])));
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !mis && (WAIT_CYCLES != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    commit_mem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall      = mem_op & ~mis & (WAIT_CYCLES != 0);
        commit_mem = mem_op & ~mis & (WAIT_CYCLES == 0);
      end
      ST_WAIT: begin
        stall      = (cnt_q != CNT_ONE);
        commit_mem = mem_op & (cnt_q == CNT_ONE);
      end
      default: ;
    endcase
  end

  // Reset must kill the stall and any pending write without waiting for a clock.
  assign stall_out = stall & ~rst;

  assign a_lo = align_lo(mem_size, alu_result[1:0]);

  always_comb begin
    case (mem_size)
      SZ_BYTE: ram_wdata = {4{store_data[7:0]}};
      SZ_HALF: ram_wdata = {2{store_data[15:0]}};
      default: ram_wdata = store_data;
    endcase
  end

  assign ram_we  = (commit_mem & mem_write & ~rst) ? lane_be(mem_size, a_lo) : 4'b0000;
  assign ld_data = load_extend(ram_rdata, mem_size, a_lo, mem_unsigned);

  mem_bytelane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (alu_result[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    wb_valid_d      = in_valid;
    wb_reg_write_d  = reg_write & ~mis;
    wb_mem_to_reg_d = mem_to_reg;
    wb_write_reg_d  = write_reg;
    wb_result_d     = alu_result;
    wb_read_data_d  = wb_read_data_q;
    misalign_d      = mis;
    if (stall) begin
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
    end else if (commit_mem && mem_read && !mem_write) begin
      wb_read_data_d = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_write_reg_q  <= '0;
      wb_read_data_q  <= '0;
      wb_result_q     <= '0;
      misalign_q      <= 1'b0;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_result_q     <= wb_result_d;
      misalign_q      <= misalign_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_result     = wb_result_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench: a zero-wait instance and a 3-wait-state instance share the input bus,
// each with its own in_valid.
module tb_mem_stage_pipe;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0, in_valid3;
  logic [31:0] alu_result, store_data;
  logic        mem_read, mem_write, mem_unsigned, reg_write, mem_to_reg;
  logic [1:0]  mem_size;
  logic [4:0]  write_reg;

  logic        stall0, wb_valid0, wb_reg_write0, wb_mem_to_reg0, misalign0;
  logic [4:0]  wb_write_reg0;
  logic [31:0] wb_read_data0, wb_result0;
  logic        stall3, wb_valid3, wb_reg_write3, wb_mem_to_reg3, misalign3;
  logic [4:0]  wb_write_reg3;
  logic [31:0] wb_read_data3, wb_result3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_pipe #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .write_reg(write_reg), .stall_out(stall0),
    .wb_valid(wb_valid0), .wb_reg_write(wb_reg_write0), .wb_mem_to_reg(wb_mem_to_reg0),
    .wb_write_reg(wb_write_reg0), .wb_read_data(wb_read_data0), .wb_result(wb_result0),
    .misalign(misalign0)
  );

  mem_stage_pipe #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .write_reg(write_reg), .stall_out(stall3),
    .wb_valid(wb_valid3), .wb_reg_write(wb_reg_write3), .wb_mem_to_reg(wb_mem_to_reg3),
    .wb_write_reg(wb_write_reg3), .wb_read_data(wb_read_data3), .wb_result(wb_result3),
    .misalign(misalign3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic v0, input logic v3, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] sd, input logic rw, input logic m2r,
                        input logic [4:0] wreg);
    in_valid0 = v0; in_valid3 = v3; mem_read = rd; mem_write = wr;
    mem_size = sz; mem_unsigned = uns; alu_result = addr; store_data = sd;
    reg_write = rw; mem_to_reg = m2r; write_reg = wreg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one memory op on the 3-wait instance through to its commit edge.
  task automatic run_op3(input string tag);
    int n;
    n = 0;
    #1;
    while (stall3 && n < 10) begin
      step();
      n++;
      chk({tag, "_bubble"}, {31'b0, wb_valid3}, 32'd0);
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd3);
    step();
    chk({tag, "_valid"}, {31'b0, wb_valid3}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_op(0, 1, 1, 0, W, 0, 32'h40, 0, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid0}, 0);
    chk("rst_wb_reg_write", {31'b0, wb_reg_write0}, 0);
    chk("rst_read_data", wb_read_data0, 0);
    chk("rst_misalign", {31'b0, misalign0}, 0);
    chk("rst_stall3", {31'b0, stall3}, 0);
    chk("rst_wb_valid3", {31'b0, wb_valid3}, 0);
    set_op(0, 0, 0, 0, W, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // zero-wait instance
    set_op(1, 0, 0, 1, W, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0); step();
    chk("sw_valid", {31'b0, wb_valid0}, 1);
    chk("sw_reg_write", {31'b0, wb_reg_write0}, 0);
    chk("sw_stall", {31'b0, stall0}, 0);
    set_op(1, 0, 1, 0, W, 0, 32'h10, 0, 1, 1, 5'd5); step();
    chk("lw_data", wb_read_data0, 32'hDEADBEEF);
    chk("lw_m2r", {31'b0, wb_mem_to_reg0}, 1);
    chk("lw_wreg", {27'b0, wb_write_reg0}, 5);
    chk("lw_result", wb_result0, 32'h10);
    set_op(1, 0, 1, 0, B, 0, 32'h13, 0, 1, 1, 5'd5); step();
    chk("lb_13", wb_read_data0, 32'hFFFFFFDE);
    set_op(1, 0, 1, 0, B, 1, 32'h13, 0, 1, 1, 5'd5); step();
    chk("lbu_13", wb_read_data0, 32'h000000DE);
    set_op(1, 0, 1, 0, H, 0, 32'h10, 0, 1, 1, 5'd5); step();
    chk("lh_10", wb_read_data0, 32'hFFFFBEEF);
    set_op(1, 0, 1, 0, H, 1, 32'h12, 0, 1, 1, 5'd5); step();
    chk("lhu_12", wb_read_data0, 32'h0000DEAD);

    set_op(1, 0, 0, 1, B, 0, 32'h11, 32'h12345655, 0, 0, 0); step();
    set_op(1, 0, 1, 0, W, 0, 32'h10, 0, 1, 1, 5'd5); step();
    chk("sb_lw", wb_read_data0, 32'hDEAD55EF);
    set_op(1, 0, 0, 1, H, 0, 32'h12, 32'hABCD1234, 0, 0, 0); step();
    set_op(1, 0, 1, 0, W, 0, 32'h10, 0, 1, 1, 5'd5); step();
    chk("sh_lw", wb_read_data0, 32'h123455EF);

    set_op(1, 0, 0, 0, W, 0, 32'hCAFEF00D, 0, 1, 0, 5'd7); step();
    chk("alu_result", wb_result0, 32'hCAFEF00D);
    chk("alu_hold_rd", wb_read_data0, 32'h123455EF);
    chk("alu_reg_write", {31'b0, wb_reg_write0}, 1);
    chk("alu_m2r", {31'b0, wb_mem_to_reg0}, 0);

    set_op(1, 0, 1, 1, W, 0, 32'h20, 32'h0BADF00D, 0, 0, 0); step();
    chk("rdwr_hold_rd", wb_read_data0, 32'h123455EF);
    set_op(1, 0, 1, 0, W, 0, 32'h20, 0, 1, 1, 5'd5); step();
    chk("rdwr_stored", wb_read_data0, 32'h0BADF00D);

    set_op(1, 0, 0, 1, W, 0, 32'h0, 32'h11223344, 0, 0, 0); step();
    set_op(1, 0, 1, 0, W, 0, 32'h402, 0, 1, 1, 5'd5); step();
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_flag", {31'b0, misalign0}, 1);
    chk("mis_reg_write", {31'b0, wb_reg_write0}, 0);
`else
    chk("wrap_lw_402", wb_read_data0, 32'h11223344);
    chk("wrap_misalign", {31'b0, misalign0}, 0);
    chk("wrap_reg_write", {31'b0, wb_reg_write0}, 1);
`endif
    set_op(1, 0, 1, 0, W, 0, 32'h410, 0, 1, 1, 5'd5); step();
    chk("wrap_lw_410", wb_read_data0, 32'h123455EF);
    chk("wrap_mis_clear", {31'b0, misalign0}, 0);
    set_op(0, 0, 0, 0, W, 0, 0, 0, 0, 0, 0); step();
    chk("idle_valid", {31'b0, wb_valid0}, 0);

    // three-wait instance
    set_op(0, 1, 0, 1, W, 0, 32'h40, 32'hA1B2C3D4, 0, 0, 0);
    run_op3("sw3");
    set_op(0, 1, 1, 0, W, 0, 32'h40, 0, 1, 1, 5'd9);
    run_op3("lw3");
    chk("lw3_data", wb_read_data3, 32'hA1B2C3D4);
    chk("lw3_reg_write", {31'b0, wb_reg_write3}, 1);
    set_op(0, 1, 1, 0, B, 1, 32'h43, 0, 1, 1, 5'd9);
    run_op3("lbu3");
    chk("lbu3_data", wb_read_data3, 32'h000000A1);
    set_op(0, 1, 0, 0, W, 0, 32'h77, 0, 1, 0, 5'd2);
    #1;
    chk("alu3_no_stall", {31'b0, stall3}, 0);
    step();
    chk("alu3_result", wb_result3, 32'h77);
    chk("alu3_valid", {31'b0, wb_valid3}, 1);

    // reset in the middle of a waited store
    set_op(0, 1, 0, 1, W, 0, 32'h40, 32'hFFFF0000, 0, 0, 0);
    step(); step();
    chk("mid_wait_stall", {31'b0, stall3}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_stall", {31'b0, stall3}, 0);
    step();
    chk("rst_wait_valid", {31'b0, wb_valid3}, 0);
    set_op(0, 0, 0, 0, W, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    set_op(0, 1, 1, 0, W, 0, 32'h40, 0, 1, 1, 5'd9);
    run_op3("lw3_after_rst");
    chk("abort_no_write", wb_read_data3, 32'hA1B2C3D4);
    set_op(0, 0, 0, 0, W, 0, 0, 0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
